lsu: RTL and testbench
======================

Name: lsu

Overview:
- Load/store unit: the initiator side of the core's strobe/busy memory bus.
- Takes one byte/half/word load or store per request from the execute stage and drives the request onto the bus.
- Bus side: word address, byte write mask, one-cycle read/write strobes; waits on the responder's busy flag.
- Returns aligned, sign- or zero-extended load data, or an error for misaligned/illegal accesses.

Parameters:
- TIMEOUT_CYCLES, 64, cycles spent in WAIT before a timeout error. Used only with LSU_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  core request present
- req_ready  out  1  LSU can accept a request (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  zero-extend load data when set
- req_addr  in  32  byte address
- req_wdata  in  32  store data, LSB-aligned
- rsp_valid  out  1  one-cycle pulse: access complete
- rsp_err  out  1  misaligned, illegal or timed out; qualified by rsp_valid
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- mem_addr  out  32  {req_addr[31:2], 2'b00}
- mem_wmask  out  4  byte-lane write enables
- mem_rstrb  out  1  read strobe, one-cycle pulse
- mem_wstrb  out  1  write strobe, one-cycle pulse
- mem_rdata  in  32  responder read data
- mem_wdata  out  32  lane-replicated store data
- mem_rbusy  in  1  responder read busy; low = rdata valid
- mem_wbusy  in  1  responder write busy; low = write done

Behaviour:
- All outputs are registered.
- Reset values: state IDLE, req_ready 1, rsp_valid 0, rsp_err 0, rsp_rdata 0, mem_addr 0, mem_wmask 0, mem_wdata 0, mem_rstrb 0, mem_wstrb 0.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Accept on req_valid & req_ready.
  - Misaligned or illegal request: go to DONE with error; no strobe is issued.
  - Misaligned means half with addr[0]=1, word with addr[1:0]!=0, or size 11.
  - Otherwise latch addr, mask, wdata, we, size, unsigned and byte offset, then go to ISSUE.
- ISSUE (exactly one cycle):
  - mem_rstrb=!we, mem_wstrb=we.
  - Busy inputs are ignored here (they may be stale).
  - Next state WAIT.
- WAIT:
  - Strobes are 0; addr/mask/wdata stay held.
  - Load: when mem_rbusy=0, capture the extracted rdata and go to DONE.
  - Store: when mem_wbusy=0, go to DONE.
- DONE:
  - rsp_valid=1 for one cycle with rsp_err and rsp_rdata; return to IDLE.
  - There is no response backpressure.
- Latency from acceptance to rsp_valid:
  - With the single-cycle RAM: 3 cycles (ISSUE, WAIT, DONE).
  - Error path: 1 cycle.
- mem_wmask:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << {addr[1],1'b0}
  - word: 4'b1111
  - loads: 0
- mem_wdata:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- Load extract:
  - Shift mem_rdata right by 8*offset.
  - Take the low 8/16/32 bits.
  - Sign-extend unless req_unsigned is set.
- Back-to-back: the next request is accepted in the IDLE cycle after DONE.
- Reset mid-transaction: the next edge forces IDLE with strobes 0; the in-flight response is dropped and never reported.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- When defined:
  - Cycle counter cleared on entry to WAIT.
  - If busy has not gone low after TIMEOUT_CYCLES WAIT cycles: go to DONE with rsp_err=1, rsp_rdata=0.
  - A late busy drop is then ignored.
- When undefined: WAIT can last indefinitely; no counter logic is synthesized.

Decomposition:
- Package lsu_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
  - state enum.
  - function computing the misalignment flag.
- Sub-module lsu_align, purely combinational:
  - inputs size, offset, unsigned, wdata, rdata.
  - outputs wmask, replicated wdata, extended rdata.
  - instantiated once.

Test Plan:
- Word load @0x10, RAM word 0xDEADBEEF:
  - mem_rstrb pulses one cycle with mem_addr=0x10.
  - rsp_valid 3 cycles after acceptance, rsp_rdata=0xDEADBEEF, rsp_err=0.
- Signed byte load @0x13, word 0x80FF7F01:
  - rsp_rdata=0xFFFFFF80.
  - Same access with unsigned set: 0x00000080.
- Half store 0x1234ABCD @0x06:
  - mem_addr=0x04, mem_wmask=1100, mem_wdata=0xABCDABCD, one mem_wstrb pulse.
  - Read-back of 0x04 has upper half 0xABCD.
- Word load @0x02 and size=11 @0x00:
  - rsp_valid the cycle after acceptance, rsp_err=1, rsp_rdata=0.
  - No strobe asserted.
- Responder holding mem_rbusy high 5 cycles:
  - LSU stays in WAIT with req_ready=0, then responds.
  - With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4: rsp_err=1.
- rst asserted during WAIT:
  - Next cycle: strobes 0, req_ready=1, no rsp_valid.
  - A new load then completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings, FSM state type and alignment check for the load/store unit.
package lsu_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

   // Size 2'b11 is illegal and folds into the same error path as misalignment.
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
      case (size)
         SZ_BYTE: misaligned = 1'b0;
         SZ_HALF: misaligned = off[0];
         SZ_WORD: misaligned = |off;
         default: misaligned = 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store mask and replicated write data, load shift and extension.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  offset,
   input  logic        uns,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  wmask,
   output logic [31:0] wdata_rep,
   output logic [31:0] rdata_ext
);

   logic [31:0] shifted;

   always_comb begin
      shifted   = rdata >> {offset, 3'b000};
      wmask     = 4'b1111;
      wdata_rep = wdata;
      rdata_ext = shifted;
      case (size)
         SZ_BYTE: begin
            wmask     = 4'b0001 << offset;
            wdata_rep = {4{wdata[7:0]}};
            rdata_ext = {{24{shifted[7] & ~uns}}, shifted[7:0]};
         end
         SZ_HALF: begin
            wmask     = 4'b0011 << {offset[1], 1'b0};
            wdata_rep = {2{wdata[15:0]}};
            rdata_ext = {{16{shifted[15] & ~uns}}, shifted[15:0]};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// Load/store unit driving the strobe/busy memory bus; all outputs registered.
// Optional WAIT timeout enabled by defining LSU_TIMEOUT_EN.
module lsu
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic        rsp_err,
   output logic [31:0] rsp_rdata,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wmask,
   output logic        mem_rstrb,
   output logic        mem_wstrb,
   input  logic [31:0] mem_rdata,
   output logic [31:0] mem_wdata,
   input  logic        mem_rbusy,
   input  logic        mem_wbusy
);

   state_e      state_q, state_d;
   logic        we_q, we_d, uns_q, uns_d;
   logic [1:0]  size_q, size_d, off_q, off_d;
   logic        ready_q, ready_d, rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d, addr_q, addr_d, wdata_q, wdata_d;
   logic [3:0]  wmask_q, wmask_d;
   logic        rstrb_q, rstrb_d, wstrb_q, wstrb_d;

   logic        al_req;
   logic [3:0]  al_wmask;
   logic [31:0] al_wdata, al_rdata;

`ifdef LSU_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CntW-1:0] cnt_q, cnt_d;
`else
   logic unused_cfg;
   assign unused_cfg = ^TIMEOUT_CYCLES;
`endif

   // One aligner: fed from the request in IDLE, from the latched fields afterwards.
   assign al_req = (state_q == StIdle);

   lsu_align u_align (
      .size      (al_req ? req_size : size_q),
      .offset    (al_req ? req_addr[1:0] : off_q),
      .uns       (al_req ? req_unsigned : uns_q),
      .wdata     (req_wdata),
      .rdata     (mem_rdata),
      .wmask     (al_wmask),
      .wdata_rep (al_wdata),
      .rdata_ext (al_rdata)
   );

   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      size_d      = size_q;
      uns_d       = uns_q;
      off_d       = off_q;
      addr_d      = addr_q;
      wmask_d     = wmask_q;
      wdata_d     = wdata_q;
      rstrb_d     = 1'b0;
      wstrb_d     = 1'b0;
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = '0;
`ifdef LSU_TIMEOUT_EN
      cnt_d       = cnt_q;
`endif
      case (state_q)
         StIdle: begin
            if (req_valid && ready_q) begin
               if (misaligned(req_size, req_addr[1:0])) begin
                  state_d     = StDone;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
               end else begin
                  state_d = StIssue;
                  we_d    = req_we;
                  size_d  = req_size;
                  uns_d   = req_unsigned;
                  off_d   = req_addr[1:0];
                  addr_d  = {req_addr[31:2], 2'b00};
                  wmask_d = req_we ? al_wmask : 4'b0000;
                  wdata_d = al_wdata;
                  rstrb_d = ~req_we;
                  wstrb_d = req_we;
               end
            end
         end
         StIssue: begin
            state_d = StWait;
`ifdef LSU_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         StWait: begin
            if (we_q ? !mem_wbusy : !mem_rbusy) begin
               state_d     = StDone;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = we_q ? 32'd0 : al_rdata;
            end
`ifdef LSU_TIMEOUT_EN
            else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
               state_d     = StDone;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   assign ready_d = (state_d == StIdle);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         we_q        <= 1'b0;
         size_q      <= SZ_BYTE;
         uns_q       <= 1'b0;
         off_q       <= 2'b00;
         ready_q     <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
         addr_q      <= '0;
         wmask_q     <= '0;
         wdata_q     <= '0;
         rstrb_q     <= 1'b0;
         wstrb_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         size_q      <= size_d;
         uns_q       <= uns_d;
         off_q       <= off_d;
         ready_q     <= ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
         addr_q      <= addr_d;
         wmask_q     <= wmask_d;
         wdata_q     <= wdata_d;
         rstrb_q     <= rstrb_d;
         wstrb_q     <= wstrb_d;
      end
   end

`ifdef LSU_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
`endif

   assign req_ready = ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;
   assign mem_addr  = addr_q;
   assign mem_wmask = wmask_q;
   assign mem_wdata = wdata_q;
   assign mem_rstrb = rstrb_q;
   assign mem_wstrb = wstrb_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed cases then random traffic against a word-array model.
module tb_lsu;

   localparam int Tmo = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_rdata, mem_addr, mem_wdata;
   logic [31:0] mem_rdata = 32'd0;
   logic [3:0]  mem_wmask;
   logic        mem_rstrb, mem_wstrb, mem_rbusy, mem_wbusy;

   logic [31:0] ram     [64];
   logic [31:0] ref_mem [64];
   int          stall_n   = 0;
   int          busy_left = 0;
   int          n_checks  = 0;
   int          n_fail    = 0;

   always #5 clk = ~clk;

   lsu #(.TIMEOUT_CYCLES(Tmo)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_err      (rsp_err),
      .rsp_rdata    (rsp_rdata),
      .mem_addr     (mem_addr),
      .mem_wmask    (mem_wmask),
      .mem_rstrb    (mem_rstrb),
      .mem_wstrb    (mem_wstrb),
      .mem_rdata    (mem_rdata),
      .mem_wdata    (mem_wdata),
      .mem_rbusy    (mem_rbusy),
      .mem_wbusy    (mem_wbusy)
   );

   // Responder: single-cycle RAM with an optional busy stretch after each strobe.
   always @(posedge clk) begin
      if (mem_rstrb) begin
         mem_rdata <= ram[mem_addr[7:2]];
         busy_left <= stall_n;
      end else if (mem_wstrb) begin
         for (int i = 0; i < 4; i++)
            if (mem_wmask[i]) ram[mem_addr[7:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
         busy_left <= stall_n;
      end else if (busy_left > 0) begin
         busy_left <= busy_left - 1;
      end
   end

   assign mem_rbusy = (busy_left != 0);
   assign mem_wbusy = (busy_left != 0);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_load(input logic [31:0] word, input int size,
                                            input logic uns, input int off);
      logic [31:0] v;
      v = word >> (8 * off);
      if (size == 0) begin
         v = v % 256;
         if (!uns && v >= 128) v = v - 256;
      end else if (size == 1) begin
         v = v % 65536;
         if (!uns && v >= 32768) v = v - 65536;
      end
      return v;
   endfunction

   task automatic txn(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata, input int stall);
      int          lat, nr, nw, off, nbytes, e_lat;
      logic        r_err, e_err, tmo;
      logic [31:0] r_rdata, s_addr, s_wdata, e_rdata, e_mask, e_wdata;
      logic [3:0]  s_mask;
      lat = 0; nr = 0; nw = 0; r_err = 1'bx; r_rdata = 'x;
      s_addr = 'x; s_wdata = 'x; s_mask = 'x;
      off = int'(addr % 4);
      e_err = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && off != 0);
      tmo = 1'b0;
`ifdef LSU_TIMEOUT_EN
      tmo = !e_err && stall >= Tmo;
`endif
      e_lat   = e_err ? 1 : (tmo ? 2 + Tmo : 3 + stall);
      e_rdata = (e_err || tmo || we) ? 32'd0 : exp_load(ref_mem[addr[7:2]], int'(size), uns, off);
      nbytes  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      e_mask  = !we ? 32'd0 : (size == 2'd0) ? (32'd1 << off) : (size == 2'd1) ? (32'd3 << off) : 32'd15;
      e_wdata = (size == 2'd0) ? (wdata % 256) * 32'h01010101 :
                (size == 2'd1) ? (wdata % 65536) * 32'h00010001 : wdata;

      @(negedge clk);
      check("req_ready_idle", {31'd0, req_ready}, 32'd1);
      stall_n = stall;
      req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
      req_addr = addr; req_wdata = wdata;
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int k = 1; k <= 40 && lat == 0; k++) begin
         @(negedge clk);
         if (mem_rstrb) begin nr++; s_addr = mem_addr; s_mask = mem_wmask; end
         if (mem_wstrb) begin nw++; s_addr = mem_addr; s_mask = mem_wmask; s_wdata = mem_wdata; end
         if (k > 1 && !(mem_rstrb || mem_wstrb) && !rsp_valid && lat == 0)
            check("ready_low_busy", {31'd0, req_ready}, 32'd0);
         if (rsp_valid) begin lat = k; r_err = rsp_err; r_rdata = rsp_rdata; end
      end
      check("rsp_latency", lat, e_lat);
      check("rsp_err", {31'd0, r_err}, {31'd0, e_err || tmo});
      check("rsp_rdata", r_rdata, e_rdata);
      check("rstrb_pulses", nr, (!e_err && !we) ? 1 : 0);
      check("wstrb_pulses", nw, (!e_err && we) ? 1 : 0);
      if (!e_err) begin
         check("mem_addr", s_addr, addr & 32'hFFFF_FFFC);
         check("mem_wmask", {28'd0, s_mask}, e_mask);
         if (we) check("mem_wdata", s_wdata, e_wdata);
      end
      if (we && !e_err)
         for (int i = 0; i < nbytes; i++)
            ref_mem[addr[7:2]][8*(off+i) +: 8] = wdata[8*i +: 8];
   endtask

   initial begin
      int nv;
      logic [1:0]  sz;
      logic [31:0] a;
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
      req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
      for (int i = 0; i < 64; i++) begin
         ram[i] = $urandom;
         ref_mem[i] = ram[i];
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", {31'd0, req_ready}, 32'd1);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wmask", {28'd0, mem_wmask}, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_strobes", {30'd0, mem_rstrb, mem_wstrb}, 32'd0);
      rst = 1'b0;

      ram[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;
      txn(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 0);
      check("word_load_value", ref_mem[4], 32'hDEADBEEF);

      ram[4] = 32'h80FF7F01; ref_mem[4] = 32'h80FF7F01;
      txn(1'b0, 2'd0, 1'b0, 32'h13, 32'd0, 0);
      txn(1'b0, 2'd0, 1'b1, 32'h13, 32'd0, 0);

      txn(1'b1, 2'd1, 1'b0, 32'h06, 32'h1234ABCD, 0);
      txn(1'b0, 2'd2, 1'b0, 32'h04, 32'd0, 0);

      txn(1'b0, 2'd2, 1'b0, 32'h02, 32'd0, 0);
      txn(1'b0, 2'd3, 1'b0, 32'h00, 32'd0, 0);

      txn(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 5);

      // Reset while the load sits in WAIT; its response must never appear.
      @(negedge clk);
      stall_n = 5;
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h20;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("mid_rst_strobes", {30'd0, mem_rstrb, mem_wstrb}, 32'd0);
      check("mid_rst_ready", {31'd0, req_ready}, 32'd1);
      nv = 0;
      for (int k = 0; k < 8; k++) begin
         if (rsp_valid) nv++;
         @(negedge clk);
      end
      check("mid_rst_no_rsp", nv, 0);
      txn(1'b0, 2'd2, 1'b0, 32'h20, 32'd0, 0);

      for (int t = 0; t < 40; t++) begin
         sz = 2'($urandom_range(0, 3));
         a  = $urandom_range(0, 255);
         if ($urandom_range(0, 1) == 1) a = a & ~((32'd1 << sz) - 32'd1);
         txn(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
             $urandom_range(0, 3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
